// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - instruction step sequencer (T0..T15); optional abort input via SEQ_ABORT_EN
module control_sequencer (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [3:0] last_step,
    input  logic       stall,
`ifdef SEQ_ABORT_EN
    input  logic       abort,
`endif
    output logic [3:0] current_state,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } seq_state_t;

    seq_state_t state, state_n;
    logic [3:0] end_step, end_step_n;
    logic [3:0] step_n;
    logic       busy_n;
    logic       done_n;
    logic       abort_req;

`ifdef SEQ_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= S_IDLE;
            current_state <= 4'd0;
            end_step      <= 4'd0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            state         <= state_n;
            current_state <= step_n;
            end_step      <= end_step_n;
            busy          <= busy_n;
            done          <= done_n;
        end
    end

    // Outputs are computed one cycle ahead so every output comes straight from a flop.
    always_comb begin
        state_n    = S_IDLE;
        step_n     = 4'd0;
        end_step_n = end_step;
        busy_n     = 1'b0;
        done_n     = 1'b0;
        unique case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_n    = S_RUN;
                    end_step_n = last_step;
                    busy_n     = 1'b1;
                end
            end
            S_RUN: begin
                if (abort_req) begin
                    state_n = S_IDLE;
                end else if (stall) begin
                    state_n = S_RUN;
                    step_n  = current_state;
                    busy_n  = 1'b1;
                end else if (current_state == end_step) begin
                    state_n = S_DONE;
                    done_n  = 1'b1;
                end else begin
                    state_n = S_RUN;
                    step_n  = current_state + 4'd1;
                    busy_n  = 1'b1;
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

endmodule
